// File: rtl/demux_1_a_4_stream_pkg.sv
// demux_1_a_4_stream_pkg: shared state encoding, channel constants and select decode.
// Rev 1.0
`default_nettype none

package demux_1_a_4_stream_pkg;

  typedef enum logic {
    VACIO = 1'b0,
    LLENO = 1'b1
  } estado_t;

  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;
  localparam logic [1:0] CH3 = 2'd3;

  function automatic logic [3:0] sel_a_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_1_a_4_stream_contador_canal.sv
// contador_canal: wrapping per-channel transfer counter, synchronous clear beats increment.
// Rev 1.0
`default_nettype none

module contador_canal #(
  parameter int CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/demux_1_a_4_stream.sv
// demux_1_a_4_stream: registered 1-to-4 valid/ready demultiplexer with per-channel transfer counters.
// Rev 1.0
`default_nettype none

module demux_1_a_4_stream
  import demux_1_a_4_stream_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_Datos,
  input  logic [1:0]    i_sel,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [N-1:0]  o_Datos,
  output logic [3:0]    o_valid,
  input  logic [3:0]    i_ready,
  output logic [CW-1:0] o_cnt_0,
  output logic [CW-1:0] o_cnt_1,
  output logic [CW-1:0] o_cnt_2,
  output logic [CW-1:0] o_cnt_3,
  input  logic          i_clr_cnt
);

  estado_t       r_estado;
  estado_t       w_estado_sig;
  logic [N-1:0]  r_word;
  logic [1:0]    r_sel;
  logic [3:0]    w_sel_oh;
  logic          w_out_fire;
  logic          w_in_fire;
  logic [CW-1:0] w_cnt [4];

  assign w_sel_oh   = sel_a_onehot(r_sel);
  assign w_out_fire = (r_estado == LLENO) & i_ready[r_sel];
  // Pass-through of the selected channel's ready lets a word leave and a new one
  // enter on the same edge.
  assign o_ready    = (r_estado == VACIO) | i_ready[r_sel];
  assign w_in_fire  = i_valid & o_ready;

  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      VACIO:   if (i_valid) w_estado_sig = LLENO;
      LLENO:   if (w_out_fire && !i_valid) w_estado_sig = VACIO;
      default: w_estado_sig = VACIO;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_estado <= VACIO;
      r_word   <= '0;
      r_sel    <= CH0;
    end else begin
      r_estado <= w_estado_sig;
      if (w_in_fire) begin
        r_word <= i_Datos;
        r_sel  <= i_sel;
      end
    end
  end

  assign o_valid = (r_estado == LLENO) ? w_sel_oh : 4'b0000;
  assign o_Datos = r_word;

  for (genvar k = 0; k < 4; k++) begin : g_cnt
    contador_canal #(
      .CW(CW)
    ) u_contador (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (w_out_fire & w_sel_oh[k]),
      .i_clr   (i_clr_cnt),
      .o_cnt   (w_cnt[k])
    );
  end

  assign o_cnt_0 = w_cnt[CH0];
  assign o_cnt_1 = w_cnt[CH1];
  assign o_cnt_2 = w_cnt[CH2];
  assign o_cnt_3 = w_cnt[CH3];

endmodule

`default_nettype wire

// File: tb/tb_demux_1_a_4_stream.sv
// tb_demux_1_a_4_stream: directed vectors, corner sequences and random traffic against a transfer-level model.
// Rev 1.0
`default_nettype none

module tb_demux_1_a_4_stream;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [3:0] i_Datos = '0;
  logic [1:0] i_sel = '0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [3:0] o_Datos;
  logic [3:0] o_valid;
  logic [3:0] i_ready = '0;
  logic [7:0] o_cnt_0, o_cnt_1, o_cnt_2, o_cnt_3;
  logic       i_clr_cnt = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  demux_1_a_4_stream #(.N(4), .CW(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_Datos(i_Datos), .i_sel(i_sel),
    .i_valid(i_valid), .o_ready(o_ready), .o_Datos(o_Datos), .o_valid(o_valid),
    .i_ready(i_ready), .o_cnt_0(o_cnt_0), .o_cnt_1(o_cnt_1), .o_cnt_2(o_cnt_2),
    .o_cnt_3(o_cnt_3), .i_clr_cnt(i_clr_cnt)
  );

  logic [7:0] w_cnt [4];
  assign w_cnt[0] = o_cnt_0;
  assign w_cnt[1] = o_cnt_1;
  assign w_cnt[2] = o_cnt_2;
  assign w_cnt[3] = o_cnt_3;

  // Transfer-level model: one pending word (or none) and a transfer tally per channel.
  bit         m_full;
  logic [3:0] m_word;
  int         m_dest;
  int         m_cnt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 0;
    m_word = '0;
    m_dest = 0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
  endtask

  // Drive one cycle of inputs, compare outputs with the model, then advance through the edge.
  task automatic step(input logic v, input logic [3:0] d, input logic [1:0] s,
                      input logic [3:0] r, input logic c);
    bit delivered, accepted;
    i_valid = v; i_Datos = d; i_sel = s; i_ready = r; i_clr_cnt = c;
    #2;
    chk("o_valid", {28'd0, o_valid}, m_full ? (32'd1 << m_dest) : 32'd0);
    chk("o_ready", {31'd0, o_ready}, (!m_full || r[m_dest]) ? 32'd1 : 32'd0);
    if (m_full) chk("o_Datos", {28'd0, o_Datos}, {28'd0, m_word});
    for (int k = 0; k < 4; k++) chk($sformatf("o_cnt_%0d", k), {24'd0, w_cnt[k]}, m_cnt[k]);
    @(posedge i_clk);
    delivered = m_full && r[m_dest];
    accepted  = v && (!m_full || delivered);
    if (c) begin
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    end else if (delivered) begin
      m_cnt[m_dest] = (m_cnt[m_dest] + 1) % 256;
    end
    if (accepted) begin
      m_full = 1; m_word = d; m_dest = int'(s);
    end else if (delivered) begin
      m_full = 0;
    end
    #1;
  endtask

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic [1:0] s;
    logic [3:0] rdy;
    logic [3:0] e_valid;
    logic       e_ready;
    logic       e_chk_d;
    logic [3:0] e_datos;
  } vec_t;

  vec_t vecs [9];

  initial begin
    // Single word to ch2, then four back-to-back words to ch0..ch3.
    vecs[0] = '{1'b1, 4'hA, 2'd2, 4'b0100, 4'b0000, 1'b1, 1'b0, 4'h0};
    vecs[1] = '{1'b0, 4'h0, 2'd0, 4'b0100, 4'b0100, 1'b1, 1'b1, 4'hA};
    vecs[2] = '{1'b0, 4'h0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'h0};
    vecs[3] = '{1'b1, 4'h1, 2'd0, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'h0};
    vecs[4] = '{1'b1, 4'h2, 2'd1, 4'b1111, 4'b0001, 1'b1, 1'b1, 4'h1};
    vecs[5] = '{1'b1, 4'h3, 2'd2, 4'b1111, 4'b0010, 1'b1, 1'b1, 4'h2};
    vecs[6] = '{1'b1, 4'h4, 2'd3, 4'b1111, 4'b0100, 1'b1, 1'b1, 4'h3};
    vecs[7] = '{1'b0, 4'h0, 2'd0, 4'b1111, 4'b1000, 1'b1, 1'b1, 4'h4};
    vecs[8] = '{1'b0, 4'h0, 2'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'h0};

    model_reset();
    #12;
    chk("rst_o_valid", {28'd0, o_valid}, 32'd0);
    chk("rst_o_Datos", {28'd0, o_Datos}, 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("rst_o_ready", {31'd0, o_ready}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      i_valid = vecs[i].v; i_Datos = vecs[i].d; i_sel = vecs[i].s; i_ready = vecs[i].rdy;
      i_clr_cnt = 1'b0;
      #2;
      chk($sformatf("vec%0d_o_valid", i), {28'd0, o_valid}, {28'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d_o_ready", i), {31'd0, o_ready}, {31'd0, vecs[i].e_ready});
      if (vecs[i].e_chk_d) chk($sformatf("vec%0d_o_Datos", i), {28'd0, o_Datos}, {28'd0, vecs[i].e_datos});
      #1;
      step(vecs[i].v, vecs[i].d, vecs[i].s, vecs[i].rdy, 1'b0);
    end
    chk("vec_cnt_0", {24'd0, o_cnt_0}, 32'd1);
    chk("vec_cnt_1", {24'd0, o_cnt_1}, 32'd1);
    chk("vec_cnt_2", {24'd0, o_cnt_2}, 32'd2);
    chk("vec_cnt_3", {24'd0, o_cnt_3}, 32'd1);

    // Stall on ch1: a competing word F must not be taken while stalled.
    step(1'b1, 4'h5, 2'd1, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 4'hF, 2'd3, 4'b0000, 1'b0);
    chk("stall_o_Datos", {28'd0, o_Datos}, 32'h5);
    chk("stall_o_valid", {28'd0, o_valid}, 32'b0010);
    chk("stall_o_ready", {31'd0, o_ready}, 32'd0);
    step(1'b0, 4'h0, 2'd0, 4'b0010, 1'b0);
    chk("stall_cnt_1", {24'd0, o_cnt_1}, 32'd2);
    step(1'b0, 4'h0, 2'd0, 4'b0000, 1'b0);

    // Ready on every channel except the destination one.
    step(1'b1, 4'h7, 2'd3, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 2'd0, 4'b0111, 1'b0);
    chk("wrongch_cnt_3", {24'd0, o_cnt_3}, 32'd1);
    chk("wrongch_o_valid", {28'd0, o_valid}, 32'b1000);
    step(1'b0, 4'h0, 2'd0, 4'b1000, 1'b0);
    step(1'b0, 4'h0, 2'd0, 4'b0000, 1'b1);

    // 256 transfers to ch0 wrap its counter back to zero.
    for (int i = 0; i < 256; i++) step(1'b1, 4'(i), 2'd0, 4'b0001, 1'b0);
    step(1'b0, 4'h0, 2'd0, 4'b0001, 1'b0);
    chk("wrap_cnt_0", {24'd0, o_cnt_0}, 32'd0);

    // Clear coincident with a ch1 delivery: clear wins.
    step(1'b1, 4'h9, 2'd1, 4'b0000, 1'b0);
    step(1'b0, 4'h0, 2'd0, 4'b0010, 1'b1);
    chk("clr_fire_cnt_1", {24'd0, o_cnt_1}, 32'd0);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 4'($urandom), 2'($urandom),
           4'($urandom), 1'($urandom_range(0, 31) == 0));

    // Asynchronous reset while a word is held.
    step(1'b1, 4'hC, 2'd2, 4'b0000, 1'b0);
    i_valid = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_o_valid", {28'd0, o_valid}, 32'd0);
    chk("midrst_o_Datos", {28'd0, o_Datos}, 32'd0);
    chk("midrst_cnt", {o_cnt_0, o_cnt_1, o_cnt_2, o_cnt_3}, 32'd0);
    model_reset();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    #1;
    chk("midrst_o_ready", {31'd0, o_ready}, 32'd1);
    step(1'b0, 4'h0, 2'd0, 4'b1111, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
